// File: rtl/urp_pcie_rx_pkg.sv
// Shared RX transaction-layer types: TLP geometry, header field offsets, scheduler state.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package urp_pcie_rx_pkg;

    // Full TLP word carried per handshake on the RX decode path.
    localparam int TLP_WIDTH = 224;

    // First-DW header field positions inside the TLP word.
    localparam int TLP_FMT_MSB  = 223;
    localparam int TLP_FMT_LSB  = 221;
    localparam int TLP_TYPE_MSB = 220;
    localparam int TLP_TYPE_LSB = 216;
    localparam int TLP_TC_MSB   = 215;
    localparam int TLP_TC_LSB   = 213;
    localparam int TLP_LEN_MSB  = 212;
    localparam int TLP_LEN_LSB  = 203;

    // Packed view of the leading header bits, MSB-first to match the offsets above.
    typedef struct packed {
        logic [2:0] fmt;
        logic [4:0] typ;
        logic [2:0] tc;
        logic [9:0] len;
    } tlp_hdr_t;

    // Scheduler FSM: IDLE arbitrates, SERVE streams the granted VC.
    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } sched_state_e;

    // Width of a VC index; never narrower than one bit.
    function automatic int vc_idx_w(input int n_vc);
        return (n_vc > 1) ? $clog2(n_vc) : 1;
    endfunction

endpackage

// File: rtl/urp_pcie_rr_pick.sv
// Rotating-priority picker: first asserted request scanning ptr, ptr+1, ... modulo N_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
module urp_pcie_rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    // Walk the requests starting at the pointer and keep the first hit.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any_o && req_i[(int'(ptr_i) + i) % N_REQ]) begin
                any_o = 1'b1;
                idx_o = IDX_W'((int'(ptr_i) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/urp_pcie_rx_vc_scheduler.sv
// Weighted round-robin share of the RX decode path across N_VC receive FIFOs.
// Latency: 1 cycle arbitration bubble per grant, then back-to-back TLPs within a quantum.
// Backpressure: dst_ready_i low holds grant, data and quantum; src pop only on accepted TLP.
module urp_pcie_rx_vc_scheduler
    import urp_pcie_rx_pkg::*;
#(
    parameter int N_VC       = 2,
    parameter int DATA_WIDTH = TLP_WIDTH,
    parameter int WEIGHT_W   = 4,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_VC-1:0]            src_valid_i,
    output logic [N_VC-1:0]            src_ready_o,
    input  logic [N_VC*DATA_WIDTH-1:0] src_data_i,
    input  logic [N_VC*WEIGHT_W-1:0]   weight_i,
    output logic                       dst_valid_o,
    input  logic                       dst_ready_i,
    output logic [DATA_WIDTH-1:0]      dst_data_o,
    output logic [$clog2(N_VC)-1:0]    dst_vc_o,
    output logic                       busy_o,
    output logic [N_VC*CNT_W-1:0]      vc_tlp_cnt_o
);

    localparam int IDX_W = vc_idx_w(N_VC);

    sched_state_e                    state_q, state_d;
    logic [IDX_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]                gnt_idx_q, gnt_idx_d;
    logic [WEIGHT_W-1:0]             quantum_cnt_q, quantum_cnt_d;
    logic [N_VC-1:0][CNT_W-1:0]      vc_tlp_cnt_q, vc_tlp_cnt_d;
    logic [DATA_WIDTH-1:0]           hold_dat_q, hold_dat_d;

    logic                            pick_any;
    logic [IDX_W-1:0]                pick_idx;
    logic [WEIGHT_W-1:0]             pick_weight;
    logic                            head_vld;
    logic [DATA_WIDTH-1:0]           head_dat;
    logic                            serve_act;

    // Successor of a VC index, wrapping at N_VC (handles non-power-of-two counts).
    function automatic logic [IDX_W-1:0] next_vc(input logic [IDX_W-1:0] idx);
        if (int'(idx) == N_VC - 1) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

    urp_pcie_rr_pick #(
        .N_REQ (N_VC),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i (src_valid_i),
        .ptr_i (rr_ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    assign pick_weight = weight_i[int'(pick_idx) * WEIGHT_W +: WEIGHT_W];
    assign head_vld    = src_valid_i[gnt_idx_q];
    assign head_dat    = src_data_i[int'(gnt_idx_q) * DATA_WIDTH +: DATA_WIDTH];

    // A pending reset silences the outputs immediately so nothing pops in the reset cycle.
    assign serve_act   = (state_q == SERVE) && !rst;

    // Next-state: arbitrate in IDLE, count quantum and statistics in SERVE.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gnt_idx_d     = gnt_idx_q;
        quantum_cnt_d = quantum_cnt_q;
        vc_tlp_cnt_d  = vc_tlp_cnt_q;
        hold_dat_d    = hold_dat_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_idx_d     = pick_idx;
                    // A zero weight would starve the VC forever; serve at least one TLP.
                    quantum_cnt_d = (pick_weight == '0) ? WEIGHT_W'(1) : pick_weight;
                    state_d       = SERVE;
                end
            end
            SERVE: begin
                if (!head_vld) begin
                    // Queue drained before the quantum ran out: hand over early.
                    rr_ptr_d = next_vc(gnt_idx_q);
                    state_d  = IDLE;
                end else begin
                    // Remember the head so the decode side sees a stable word after the grant.
                    hold_dat_d = head_dat;
                    if (dst_ready_i) begin
                        vc_tlp_cnt_d[gnt_idx_q] = vc_tlp_cnt_q[gnt_idx_q] + CNT_W'(1);
                        quantum_cnt_d           = quantum_cnt_q - WEIGHT_W'(1);
                        if (quantum_cnt_q == WEIGHT_W'(1)) begin
                            rr_ptr_d = next_vc(gnt_idx_q);
                            state_d  = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            gnt_idx_q     <= '0;
            quantum_cnt_q <= '0;
            vc_tlp_cnt_q  <= '0;
            hold_dat_q    <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_idx_q     <= gnt_idx_d;
            quantum_cnt_q <= quantum_cnt_d;
            vc_tlp_cnt_q  <= vc_tlp_cnt_d;
            hold_dat_q    <= hold_dat_d;
        end
    end

    // Pop strobe: one-hot at the grant, only when the decode stage takes the head.
    always_comb begin
        src_ready_o = '0;
        if (serve_act && head_vld && dst_ready_i) begin
            src_ready_o[gnt_idx_q] = 1'b1;
        end
    end

    assign dst_valid_o  = serve_act && head_vld;
    assign dst_data_o   = serve_act ? head_dat : hold_dat_q;
    assign dst_vc_o     = gnt_idx_q;
    assign busy_o       = serve_act;
    assign vc_tlp_cnt_o = vc_tlp_cnt_q;

endmodule

// File: tb/tb_urp_pcie_rx_vc_scheduler.sv
// Directed bench for the RX VC scheduler with queue-modelled source FIFOs.
// Latency: checks sampled mid-cycle, away from the rising edge.
// Backpressure: dst_ready_i driven directly by the step sequence.
module tb_urp_pcie_rx_vc_scheduler;

    logic         clk;
    logic         rst;
    logic [1:0]   src_valid_i;
    logic [1:0]   src_ready_o;
    logic [447:0] src_data_i;
    logic [7:0]   weight_i;
    logic         dst_valid_o;
    logic         dst_ready_i;
    logic [223:0] dst_data_o;
    logic [0:0]   dst_vc_o;
    logic         busy_o;
    logic [31:0]  vc_tlp_cnt_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit vc1_pop_seen = 0;
    int s0, s1;

    logic [223:0] q0[$];
    logic [223:0] q1[$];
    int           log_vc[$];
    int           log_cyc[$];
    logic [223:0] log_dat[$];

    int exp2[8] = '{0, 0, 0, 1, 0, 1, 1, 1};
    int exp6[8] = '{0, 0, 0, 1, 0, 1, 0, 0};

    urp_pcie_rx_vc_scheduler #(
        .N_VC       (2),
        .DATA_WIDTH (224),
        .WEIGHT_W   (4),
        .CNT_W      (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_valid_i  (src_valid_i),
        .src_ready_o  (src_ready_o),
        .src_data_i   (src_data_i),
        .weight_i     (weight_i),
        .dst_valid_o  (dst_valid_o),
        .dst_ready_i  (dst_ready_i),
        .dst_data_o   (dst_data_o),
        .dst_vc_o     (dst_vc_o),
        .busy_o       (busy_o),
        .vc_tlp_cnt_o (vc_tlp_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [223:0] mk(input int v, input int k);
        logic [223:0] r;
        r            = '0;
        r[223:216]   = 8'(v + 1);
        r[111:104]   = 8'hA5;
        r[15:0]      = 16'(k + 1);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        src_valid_i[0]       = (q0.size() != 0);
        src_valid_i[1]       = (q1.size() != 0);
        src_data_i[223:0]    = (q0.size() != 0) ? q0[0] : '0;
        src_data_i[447:224]  = (q1.size() != 0) ? q1[0] : '0;
    endtask

    task automatic fill(input int v, input int n);
        for (int k = 0; k < n; k++) begin
            if (v == 0) q0.push_back(mk(0, k));
            else        q1.push_back(mk(1, k));
        end
        drive_src();
    endtask

    // One clock: sample handshake mid-cycle, pop modelled FIFOs at the edge, re-drive.
    task automatic tick();
        logic [1:0] pops;
        #3;
        pops = src_ready_o;
        if (src_ready_o[1]) vc1_pop_seen = 1'b1;
        if (dst_valid_o && dst_ready_i) begin
            log_vc.push_back(int'(dst_vc_o));
            log_cyc.push_back(cyc);
            log_dat.push_back(dst_data_o);
        end
        @(posedge clk);
        cyc++;
        if (pops[0] && q0.size() != 0) void'(q0.pop_front());
        if (pops[1] && q1.size() != 0) void'(q1.pop_front());
        #1;
        drive_src();
        #1;
    endtask

    task automatic run_until(input int n, input int budget);
        for (int i = 0; i < budget && log_vc.size() < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        drive_src();
        tick();
        rst = 1'b0;
        log_vc.delete();
        log_cyc.delete();
        log_dat.delete();
        vc1_pop_seen = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        dst_ready_i = 1'b1;
        weight_i    = 8'h22;
        src_valid_i = '0;
        src_data_i  = '0;
        @(posedge clk);
        #2;

        // Reset with both VCs valid, weights 2/2.
        fill(0, 2);
        fill(1, 2);
        tick();
        chk("rst_valid", dst_valid_o, 1'b0);
        chk("rst_ready", src_ready_o, 2'b00);
        chk("rst_busy",  busy_o, 1'b0);
        chk("rst_vc",    dst_vc_o, 1'b0);
        chk("rst_data",  dst_data_o, 224'd0);
        chk("rst_cnt",   vc_tlp_cnt_o, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_valid", dst_valid_o, 1'b0);
        chk("post_rst_ready", src_ready_o, 2'b00);
        tick();
        chk("first_gnt_valid", dst_valid_o, 1'b1);
        chk("first_gnt_vc",    dst_vc_o, 1'b0);
        chk("first_gnt_data",  dst_data_o, mk(0, 0));
        chk("first_gnt_pop",   src_ready_o, 2'b01);
        chk("first_gnt_busy",  busy_o, 1'b1);

        // Weights 3/1, four TLPs each, decode always ready.
        do_reset();
        weight_i    = 8'h13;
        dst_ready_i = 1'b1;
        fill(0, 4);
        fill(1, 4);
        run_until(8, 40);
        chk("t2_len", log_vc.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t2_order%0d", i), log_vc[i], exp2[i]);
        chk("t2_b2b",     log_cyc[1] - log_cyc[0], 1);
        chk("t2_bubble1", log_cyc[3] - log_cyc[2], 2);
        chk("t2_bubble2", log_cyc[4] - log_cyc[3], 2);
        chk("t2_data3",   log_dat[3], mk(1, 0));
        chk("t2_data4",   log_dat[4], mk(0, 3));
        chk("t2_cnt0",    vc_tlp_cnt_o[15:0], 16'd4);
        chk("t2_cnt1",    vc_tlp_cnt_o[31:16], 16'd4);

        // VC0 alone with weight 0 behaves as quantum 1.
        do_reset();
        weight_i = 8'h00;
        fill(0, 3);
        tick();
        tick();
        chk("t3_bubble_valid", dst_valid_o, 1'b0);
        chk("t3_bubble_busy",  busy_o, 1'b0);
        chk("t3_hold_data",    dst_data_o, mk(0, 0));
        chk("t3_hold_vc",      dst_vc_o, 1'b0);
        run_until(3, 20);
        chk("t3_len",  log_vc.size(), 3);
        chk("t3_gap1", log_cyc[1] - log_cyc[0], 2);
        chk("t3_gap2", log_cyc[2] - log_cyc[1], 2);
        chk("t3_vc2",  log_vc[2], 0);
        chk("t3_vc1_pop", vc1_pop_seen, 1'b0);
        chk("t3_cnt0", vc_tlp_cnt_o[15:0], 16'd3);

        // VC1 granted, decode stalls for five cycles.
        do_reset();
        weight_i    = 8'h20;
        dst_ready_i = 1'b0;
        fill(1, 2);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_stall_valid%0d", i), dst_valid_o, 1'b1);
            chk($sformatf("t4_stall_vc%0d", i),    dst_vc_o, 1'b1);
            chk($sformatf("t4_stall_pop%0d", i),   src_ready_o, 2'b00);
            chk($sformatf("t4_stall_data%0d", i),  dst_data_o, mk(1, 0));
            tick();
        end
        chk("t4_stall_cnt", vc_tlp_cnt_o[31:16], 16'd0);
        dst_ready_i = 1'b1;
        #1;
        chk("t4_release_pop", src_ready_o, 2'b10);
        tick();
        chk("t4_single_pop", q1.size(), 1);
        chk("t4_log1", log_vc.size(), 1);
        tick();
        chk("t4_log2", log_vc.size(), 2);
        chk("t4_b2b",  log_cyc[1] - log_cyc[0], 1);
        chk("t4_cnt1", vc_tlp_cnt_o[31:16], 16'd2);

        // VC0 drains early under a large weight; VC1 waiting.
        do_reset();
        weight_i = 8'h18;
        fill(0, 2);
        fill(1, 1);
        run_until(3, 20);
        chk("t5_len",    log_vc.size(), 3);
        chk("t5_vc",     log_vc[2], 1);
        chk("t5_b2b",    log_cyc[1] - log_cyc[0], 1);
        chk("t5_switch", log_cyc[2] - log_cyc[1], 3);

        // Weight of VC0 drops from 3 to 1 after the first transfer of its quantum.
        do_reset();
        weight_i = 8'h13;
        fill(0, 5);
        fill(1, 2);
        run_until(1, 10);
        chk("t6_first", log_vc.size(), 1);
        weight_i = 8'h11;
        run_until(8, 40);
        chk("t6_len", log_vc.size(), 7);
        for (int i = 0; i < 7; i++) chk($sformatf("t6_order%0d", i), log_vc[i], exp6[i]);
        chk("t6_newq", log_cyc[5] - log_cyc[4], 2);

        // Synchronous reset in the middle of a VC1 quantum.
        do_reset();
        weight_i = 8'h41;
        fill(0, 2);
        fill(1, 4);
        run_until(2, 20);
        chk("t7_pre_vc", dst_vc_o, 1'b1);
        rst = 1'b1;
        #1;
        chk("t7_rst_pop",   src_ready_o, 2'b00);
        chk("t7_rst_valid", dst_valid_o, 1'b0);
        s0 = q0.size();
        s1 = q1.size();
        tick();
        rst = 1'b0;
        #1;
        chk("t7_idle_valid", dst_valid_o, 1'b0);
        chk("t7_idle_pop",   src_ready_o, 2'b00);
        tick();
        chk("t7_q0_hold", q0.size(), s0);
        chk("t7_q1_hold", q1.size(), s1);
        chk("t7_regrant_vc",   dst_vc_o, 1'b0);
        chk("t7_regrant_busy", busy_o, 1'b1);
        chk("t7_cnt", vc_tlp_cnt_o, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
